// File: rtl/ram_march_bist.sv
// March BIST initiator/checker: w(P) asc, r(P)w(~P) asc, r(~P) desc, then RD_LAT drain; busy 4*DEPTH+RD_LAT cycles.
// No backpressure: strobes issue every cycle while busy. Optional first-fail log under RAM_BIST_FAIL_LOG_EN.
module ram_march_bist #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int DEPTH      = 1024,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] fail_count,
   output logic [ADDR_WIDTH-1:0] first_fail_addr,
   output logic [DATA_WIDTH-1:0] first_fail_data,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  write_enable,
   output logic                  read_enable,
   output logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] data_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_M0_W_ASC, S_M1_RW_ASC, S_M2_R_DESC, S_DRAIN, S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [2:0]            DRAIN_INIT = 3'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    phase_q, phase_d;
   logic [2:0]              drain_q, drain_d;
   logic [DATA_WIDTH-1:0]   pat_q;
   logic [ADDR_WIDTH+1:0]   fail_count_q;
   logic [ADDR_WIDTH-1:0]   wa_q, ra_q;
   logic [DATA_WIDTH-1:0]   di_q;
   logic                    accept;
   logic                    we, re;
   logic [DATA_WIDTH-1:0]   wdat, rexp;
   logic                    cmp_vld;
   logic [DATA_WIDTH-1:0]   cmp_exp;
   logic                    mismatch;

   assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         phase_q <= 1'b0;
         drain_q <= '0;
         pat_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         phase_q <= phase_d;
         drain_q <= drain_d;
         if (accept) pat_q <= pattern;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      drain_d = drain_q;
      we      = 1'b0;
      re      = 1'b0;
      wdat    = '0;
      rexp    = '0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_d = S_M0_W_ASC;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end
         S_M0_W_ASC: begin
            we   = 1'b1;
            wdat = pat_q;
            if (addr_q == LAST_ADDR) begin
               state_d = S_M1_RW_ASC;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_M1_RW_ASC: begin
            // Read then write the same address on alternate cycles.
            if (!phase_q) begin
               re      = 1'b1;
               rexp    = pat_q;
               phase_d = 1'b1;
            end else begin
               we      = 1'b1;
               wdat    = ~pat_q;
               phase_d = 1'b0;
               if (addr_q == LAST_ADDR) state_d = S_M2_R_DESC;
               else                     addr_d  = addr_q + 1'b1;
            end
         end
         S_M2_R_DESC: begin
            re   = 1'b1;
            rexp = ~pat_q;
            if (addr_q == '0) begin
               state_d = (RD_LAT == 0) ? S_DONE : S_DRAIN;
               drain_d = DRAIN_INIT;
            end else begin
               addr_d = addr_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign write_enable = we;
   assign read_enable  = re;
   assign write_addr   = we ? addr_q : wa_q;
   assign read_addr    = re ? addr_q : ra_q;
   assign data_in      = we ? wdat : di_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wa_q <= '0;
         ra_q <= '0;
         di_q <= '0;
      end else begin
         wa_q <= write_addr;
         ra_q <= read_addr;
         di_q <= data_in;
      end
   end

   assign busy = (state_q == S_M0_W_ASC) || (state_q == S_M1_RW_ASC) ||
                 (state_q == S_M2_R_DESC) || (state_q == S_DRAIN);
   assign done = (state_q == S_DONE);
   assign pass = done && (fail_count_q == '0);
   assign fail_count = fail_count_q;

`ifdef RAM_BIST_FAIL_LOG_EN
   logic [ADDR_WIDTH-1:0] cmp_addr;
`endif

   generate
      if (RD_LAT == 0) begin : g_lat0
         assign cmp_vld = re;
         assign cmp_exp = rexp;
`ifdef RAM_BIST_FAIL_LOG_EN
         assign cmp_addr = addr_q;
`endif
      end else begin : g_pipe
         logic                  pv [RD_LAT];
         logic [DATA_WIDTH-1:0] pe [RD_LAT];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < RD_LAT; i++) begin
                  pv[i] <= 1'b0;
                  pe[i] <= '0;
               end
            end else begin
               pv[0] <= re;
               pe[0] <= rexp;
               for (int i = 1; i < RD_LAT; i++) begin
                  pv[i] <= pv[i-1];
                  pe[i] <= pe[i-1];
               end
            end
         end
         assign cmp_vld = pv[RD_LAT-1];
         assign cmp_exp = pe[RD_LAT-1];
`ifdef RAM_BIST_FAIL_LOG_EN
         logic [ADDR_WIDTH-1:0] pa [RD_LAT];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
            end else begin
               pa[0] <= addr_q;
               for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
            end
         end
         assign cmp_addr = pa[RD_LAT-1];
`endif
      end
   endgenerate

   assign mismatch = cmp_vld && (data_out != cmp_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              fail_count_q <= '0;
      else if (accept)                         fail_count_q <= '0;
      else if (mismatch && (fail_count_q != '1)) fail_count_q <= fail_count_q + 1'b1;
   end

`ifdef RAM_BIST_FAIL_LOG_EN
   logic [ADDR_WIDTH-1:0] ffa_q;
   logic [DATA_WIDTH-1:0] ffd_q;
   // A zero count at mismatch time marks the first failure of the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ffa_q <= '0;
         ffd_q <= '0;
      end else if (accept) begin
         ffa_q <= '0;
         ffd_q <= '0;
      end else if (mismatch && (fail_count_q == '0)) begin
         ffa_q <= cmp_addr;
         ffd_q <= data_out;
      end
   end
   assign first_fail_addr = ffa_q;
   assign first_fail_data = ffd_q;
`else
   assign first_fail_addr = '0;
   assign first_fail_data = '0;
`endif

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Initiator and checker for the single-port-pair RAM interface: write_addr, read_addr, write_enable, read_enable, data_in, data_out.
- Drives a 3-element march test against a ParameterizedRAM instance and compares every read against the expected value.
- Reports pass/fail, failure count and first failing location.
- Sits between the system controller (start/status) and the RAM under test.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- DEPTH, 1024, words tested (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_WIDTH, DEPTH >= 2.
- RD_LAT, 1, cycles from read_enable/read_addr sample to valid data_out (0..4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  single-cycle request; accepted only in IDLE or DONE.
- pattern  in  DATA_WIDTH  background P; sampled on accepted start.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid while done=1; 1 iff fail_count==0.
- fail_count  out  ADDR_WIDTH+2  mismatching reads, saturating.
- first_fail_addr  out  ADDR_WIDTH  address of first mismatch (see Optional Feature).
- first_fail_data  out  DATA_WIDTH  data_out observed at first mismatch (see Optional Feature).
- write_addr  out  ADDR_WIDTH  RAM write address.
- read_addr  out  ADDR_WIDTH  RAM read address.
- write_enable  out  1  RAM write strobe.
- read_enable  out  1  RAM read strobe.
- data_in  out  DATA_WIDTH  RAM write data.
- data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: busy, done, pass, fail_count, first_fail_*, addresses, strobes, data_in.
  - Compare pipeline cleared.
- FSM states: IDLE -> M0_W_ASC -> M1_RW_ASC -> M2_R_DESC -> DRAIN -> DONE; DONE -> M0 on start.
- On accepted start:
  - Capture P.
  - Clear fail_count, first_fail_*, done and pass.
  - busy=1 from the next cycle.
  - start while busy is ignored.
- M0 (ascending, 1 cycle per address): write_enable=1, write_addr=a, data_in=P; a = 0..DEPTH-1.
- M1 (ascending, 2 cycles per address):
  - Read cycle: read_enable=1, read_addr=a, expect P.
  - Write cycle: write_enable=1, write_addr=a, data_in=~P.
  - Never both strobes in one cycle.
- M2 (descending, 1 cycle per address): read_enable=1, read_addr=a, expect ~P; a = DEPTH-1..0.
- Strobes are 0 outside M0-M2. Address outputs hold their last value when idle.
- Compare pipeline:
  - RD_LAT-deep shift register of {valid, addr, expected}, loaded on each read cycle.
  - data_out is compared when a valid entry exits.
  - RD_LAT=0: compare in the same cycle as the read.
- Mismatch:
  - fail_count += 1, saturating at all-ones.
  - On the first mismatch only, latch first_fail_addr/first_fail_data.
- DRAIN: RD_LAT cycles, so every issued read is compared.
- Entering DONE: busy=0, done=1, pass=(fail_count==0 including the final compare).
- Total busy duration: 4*DEPTH + RD_LAT cycles.
- Address counter width is ADDR_WIDTH; the last index is DEPTH-1 with no wrap past it. Descending stops at 0 with no underflow wrap.
- rst_n asserted mid-test: immediate return to IDLE, strobes drop asynchronously, results lost.
- pattern changing while busy has no effect.

Optional Feature:
- Macro: RAM_BIST_FAIL_LOG_EN.
- Defined: first_fail_addr/first_fail_data captured as above.
- Undefined:
  - Both ports tied to 0 and no capture registers are built.
  - fail_count/pass behave identically.

Test Plan:
- Fault-free RAM model, DEPTH=16, RD_LAT=1, P=8'hAA, start pulse:
  - busy high exactly 65 cycles.
  - done=1, pass=1, fail_count=0.
  - Exactly 16 writes of AA, then 16 writes of 55.
- RAM model with bit 0 of address 5 stuck-at-1, P=8'hAA, DEPTH=16:
  - M1 read mismatches (AB vs AA); M2 read matches (55).
  - fail_count=1, pass=0.
  - With macro: first_fail_addr=5, first_fail_data=8'hAB.
- Address 3 stuck-at-0x00 for all bits, P=8'h0F:
  - fail_count=2, pass=0.
  - first_fail_addr=3, first_fail_data=00 (macro on), 0/0 with macro off.
- start pulsed at cycle 10 of an active run:
  - Ignored; run completes at cycle 65 unchanged.
  - Second start after done restarts and clears fail_count.
- rst_n low at cycle 20 of a run:
  - Same-cycle drop of write_enable/read_enable.
  - All outputs 0; fresh start completes with pass=1.
- RD_LAT=0 and RD_LAT=3 builds, fault-free, DEPTH=16:
  - busy 64 and 67 cycles respectively.
  - pass=1.
